// File: rtl/seq_shift_pkg.sv
// rtl/seq_shift_pkg.sv - shared types and mode encoding for the sequential shifter
package seq_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit positions inside the latched mode register
    localparam int MODE_DIR   = 0;
    localparam int MODE_ARITH = 1;
    localparam int MODE_ROT   = 2;
    localparam int MODE_W     = 3;

    function automatic logic [MODE_W-1:0] pack_mode(
        input logic lr_en,
        input logic al_en,
        input logic rot_en
    );
        logic [MODE_W-1:0] m;
        m = '0;
        m[MODE_DIR]   = lr_en;
        m[MODE_ARITH] = al_en;
        m[MODE_ROT]   = rot_en;
        return m;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-position shift/rotate step
module shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] w,
    input  logic             lr_en,
    input  logic             al_en,
    input  logic             rot_en,
    output logic [WIDTH-1:0] next_w
);

    // Rotate takes precedence over arithmetic; arithmetic only matters going right
    always_comb begin
        next_w = w;
        if (lr_en) begin
            if (rot_en) begin
                next_w = {w[WIDTH-2:0], w[WIDTH-1]};
            end else begin
                next_w = {w[WIDTH-2:0], 1'b0};
            end
        end else if (rot_en) begin
            next_w = {w[0], w[WIDTH-1:1]};
        end else if (al_en) begin
            next_w = {w[WIDTH-1], w[WIDTH-1:1]};
        end else begin
            next_w = {1'b0, w[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_shift.sv
// rtl/seq_shift.sv - iterative one-bit-per-clock shifter with start/busy/done handshake
module seq_shift
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lr_en,
    input  logic             al_en,
    input  logic             rot_en,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    state_t            state;
    logic [WIDTH-1:0]  work;
    logic [WIDTH-1:0]  step_w;
    logic [SHW-1:0]    count;
    logic [MODE_W-1:0] mode;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .w      (work),
        .lr_en  (mode[MODE_DIR]),
        .al_en  (mode[MODE_ARITH]),
        .rot_en (mode[MODE_ROT]),
        .next_w (step_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
            mode  <= '0;
            dout  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= din;
                        count <= shamt;
                        mode  <= pack_mode(lr_en, al_en, rot_en);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Counter only decrements while nonzero, so it cannot wrap
                    if (count == '0) begin
                        dout  <= work;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        work  <= step_w;
                        count <= count - SHW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift.sv
// tb/tb_seq_shift.sv - directed self-checking bench for seq_shift
module tb_seq_shift;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             lr_en;
    logic             al_en;
    logic             rot_en;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_shift #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lr_en  (lr_en),
        .al_en  (al_en),
        .rot_en (rot_en),
        .shamt  (shamt),
        .din    (din),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    typedef struct {
        logic [WIDTH-1:0] din;
        logic [SHW-1:0]   shamt;
        logic             lr;
        logic             al;
        logic             rot;
        logic [WIDTH-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept at E0, expect done after E(shamt+1), busy low after E(shamt+2)
    task automatic run_op(input string name, input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                          input logic lr, input logic al, input logic rot,
                          input logic [WIDTH-1:0] exp);
        int edges;
        int busy_bad;
        bit got;
        @(negedge clk);
        din = d; shamt = s; lr_en = lr; al_en = al; rot_en = rot; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; din = ~d; shamt = ~s; lr_en = ~lr; rot_en = ~rot;
        edges = 0; busy_bad = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) got = 1;
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, edges, int'(s) + 1);
        check({name, " dout"}, dout, exp);
        check({name, " busy_during"}, busy_bad, 0);
        check({name, " busy_in_done"}, busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check({name, " done_one_cycle"}, done, 1'b0);
        check({name, " busy_dropped"}, busy, 1'b0);
        check({name, " dout_held"}, dout, exp);
    endtask

    vec_t vecs[$];

    initial begin
        int extra_done;

        vecs.push_back('{8'h96, 3'd3, 1'b1, 1'b0, 1'b0, 8'hB0});
        vecs.push_back('{8'h96, 3'd2, 1'b0, 1'b1, 1'b0, 8'hE5});
        vecs.push_back('{8'h96, 3'd2, 1'b0, 1'b0, 1'b0, 8'h25});
        vecs.push_back('{8'h76, 3'd2, 1'b0, 1'b1, 1'b0, 8'h1D});
        vecs.push_back('{8'h96, 3'd3, 1'b0, 1'b1, 1'b1, 8'hD2});
        vecs.push_back('{8'h96, 3'd7, 1'b1, 1'b1, 1'b1, 8'h4B});
        vecs.push_back('{8'h96, 3'd1, 1'b1, 1'b1, 1'b0, 8'h2C});
        vecs.push_back('{8'h81, 3'd7, 1'b0, 1'b1, 1'b0, 8'hFF});
        vecs.push_back('{8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A});

        // Reset held with start asserted must not launch an operation
        rst = 1'b1; start = 1'b1; din = 8'hFF; shamt = 3'd1;
        lr_en = 1'b1; al_en = 1'b0; rot_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset dout", dout, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_reset busy", busy, 1'b0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].shamt,
                   vecs[i].lr, vecs[i].al, vecs[i].rot, vecs[i].exp);
        end

        // shamt=0 with start re-asserted through SHIFT and DONE
        @(negedge clk);
        din = 8'h5A; shamt = 3'd0; lr_en = 1'b0; al_en = 1'b0; rot_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din = 8'hFF; shamt = 3'd2;
        check("ovl busy_e0", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("ovl done_e1", done, 1'b1);
        check("ovl dout_e1", dout, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ovl busy_e2", busy, 1'b0);
        check("ovl done_e2", done, 1'b0);
        extra_done = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        check("ovl no_second_op", extra_done, 0);
        check("ovl dout_kept", dout, 8'h5A);

        // Reset in mid-operation discards the work
        @(negedge clk);
        din = 8'h96; shamt = 3'd7; lr_en = 1'b1; al_en = 1'b0; rot_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy, 1'b0);
        check("midrst dout", dout, 8'h00);
        check("midrst done", done, 1'b0);
        extra_done = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        check("midrst no_done", extra_done, 0);
        check("midrst dout_stays", dout, 8'h00);
        run_op("after_rst", 8'h01, 3'd1, 1'b1, 1'b0, 1'b0, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
